ofifo_col: RTL and testbench

- Column-parallel output FIFO between the MAC array and the SFU accumulate/ReLU stage.
- Each array column pushes psums into its own lane independently.
- The consumer sees one full row (all lanes) at a time through a valid/read pop interface.
- The block is the producer end of the ofifo_out / ofifo_valid / ofifo_rd interface.

---
 rtl/ofifo_col_if.sv | 33 +++
 rtl/ofifo_col.sv | 115 +++++++++++
 tb/tb_ofifo_col.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ofifo_col_if.sv
// ofifo_col_if: bundle between the MAC array / SFU and the column output FIFO.
//   in, wr      : per-lane psum write data and push strobes (from the array)
//   rd          : pop one full row (from the consumer)
//   o_valid     : every lane holds at least one entry
//   o_out       : head entry of each lane, zero when o_valid=0
//   o_full      : some lane holds depth entries; o_ready = ~o_full
//   o_overflow  : sticky, a push was dropped on a full lane
//   o_underflow : sticky, rd seen while o_valid=0
// master drives in/wr/rd; slave is the FIFO itself.
interface ofifo_col_if #(
    parameter int col     = 8,
    parameter int psum_bw = 16
);
    logic [col*psum_bw-1:0] in;
    logic [col-1:0]         wr;
    logic                   rd;
    logic                   o_valid;
    logic [col*psum_bw-1:0] o_out;
    logic                   o_full;
    logic                   o_ready;
    logic                   o_overflow;
    logic                   o_underflow;

    modport master (
        output in, wr, rd,
        input  o_valid, o_out, o_full, o_ready, o_overflow, o_underflow
    );

    modport slave (
        input  in, wr, rd,
        output o_valid, o_out, o_full, o_ready, o_overflow, o_underflow
    );
endinterface

// File: rtl/ofifo_col.sv
// ofifo_col: column-parallel output FIFO between the MAC array and the SFU.
// Each column pushes into its own lane independently; the consumer pops a
// whole row (all lanes) at once through a show-ahead valid/rd interface.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high; clears pointers, counts and flags
//   bus   : ofifo_col_if slave (in/wr/rd in, o_* status and data out)
module ofifo_col #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 64,
    parameter int ptr_bw  = 6
) (
    input  logic        clk,
    input  logic        reset,
    ofifo_col_if.slave  bus
);
    localparam logic [ptr_bw:0]   FULL_CNT = (ptr_bw+1)'(depth);
    localparam logic [ptr_bw:0]   CNT_ONE  = (ptr_bw+1)'(1);
    localparam logic [ptr_bw-1:0] PTR_ONE  = ptr_bw'(1);

    logic [psum_bw-1:0] mem_q    [col][depth];
    logic [ptr_bw-1:0]  wr_ptr_q [col];
    logic [ptr_bw-1:0]  wr_ptr_d [col];
    logic [ptr_bw-1:0]  rd_ptr_q [col];
    logic [ptr_bw-1:0]  rd_ptr_d [col];
    logic [ptr_bw:0]    count_q  [col];
    logic [ptr_bw:0]    count_d  [col];
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;

    logic [col-1:0]         lane_nonempty;
    logic [col-1:0]         lane_full;
    logic [col-1:0]         push_ok;
    logic                   valid;
    logic                   pop_ok;
    logic [col*psum_bw-1:0] out_d;

    // Lane status from registered counts only (no lookahead).
    always_comb begin
        lane_nonempty = '0;
        lane_full     = '0;
        for (int unsigned i = 0; i < col; i++) begin
            lane_nonempty[i] = (count_q[i] != '0);
            lane_full[i]     = (count_q[i] == FULL_CNT);
        end
        valid  = &lane_nonempty;
        pop_ok = bus.rd & valid;
    end

    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q | (bus.rd & ~valid);
        push_ok     = '0;
        out_d       = '0;
        for (int unsigned i = 0; i < col; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i];
            rd_ptr_d[i] = rd_ptr_q[i];
            count_d[i]  = count_q[i];
            // A full lane still accepts a push when the row pop frees a slot.
            push_ok[i] = bus.wr[i] & (~lane_full[i] | pop_ok);
            if (bus.wr[i] && !push_ok[i]) begin
                overflow_d = 1'b1;
            end
            if (push_ok[i]) begin
                wr_ptr_d[i] = wr_ptr_q[i] + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr_d[i] = rd_ptr_q[i] + PTR_ONE;
            end
            case ({push_ok[i], pop_ok})
                2'b10:   count_d[i] = count_q[i] + CNT_ONE;
                2'b01:   count_d[i] = count_q[i] - CNT_ONE;
                default: count_d[i] = count_q[i];
            endcase
            out_d[i*psum_bw +: psum_bw] = valid ? mem_q[i][rd_ptr_q[i]] : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < col; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < col; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                count_q[i]  <= count_d[i];
            end
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < col; i++) begin
            if (push_ok[i]) begin
                mem_q[i][wr_ptr_q[i]] <= bus.in[i*psum_bw +: psum_bw];
            end
        end
    end

    assign bus.o_valid     = valid;
    assign bus.o_out       = out_d;
    assign bus.o_full      = |lane_full;
    assign bus.o_ready     = ~(|lane_full);
    assign bus.o_overflow  = overflow_q;
    assign bus.o_underflow = underflow_q;
endmodule

// File: tb/tb_ofifo_col.sv
// tb_ofifo_col: directed, table-driven bench for ofifo_col (8 lanes x 16 bit,
// depth 64). Inputs are driven 1 ns after the rising edge and outputs are
// sampled at that same point, after the state has settled.
module tb_ofifo_col;
    localparam int COL = 8;
    localparam int PBW = 16;
    localparam int W   = COL * PBW;

    logic clk;
    logic reset;

    ofifo_col_if #(.col(COL), .psum_bw(PBW)) bus ();

    ofifo_col #(.col(COL), .psum_bw(PBW), .depth(64), .ptr_bw(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [COL-1:0] wr;
        logic [W-1:0]   din;
        logic           rd;
        logic           ev;
        logic [W-1:0]   eout;
        logic           eunf;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] fill(input logic [PBW-1:0] v);
        return {COL{v}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr = '0;
        bus.rd = 1'b0;
        bus.in = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic push_row(input logic [PBW-1:0] v);
        bus.wr = '1;
        bus.in = fill(v);
        bus.rd = 1'b0;
        tick();
        idle();
    endtask

    task automatic pop_row();
        bus.wr = '0;
        bus.rd = 1'b1;
        tick();
        idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] row_a;
        logic [W-1:0] skew;

        row_a = '0;
        for (int i = 0; i < COL; i++) row_a[i*PBW +: PBW] = PBW'(i + 1);
        skew = {{4{16'h00BB}}, {4{16'h00AA}}};

        //           wr      din             rd    ev    eout    eunf
        tbl[0] = '{8'hFF, row_a,          1'b0, 1'b1, row_a, 1'b0};
        tbl[1] = '{8'h00, '0,             1'b1, 1'b0, '0,    1'b0};
        tbl[2] = '{8'h0F, fill(16'h00AA), 1'b0, 1'b0, '0,    1'b0};
        tbl[3] = '{8'h00, '0,             1'b0, 1'b0, '0,    1'b0};
        tbl[4] = '{8'h00, '0,             1'b0, 1'b0, '0,    1'b0};
        tbl[5] = '{8'hF0, fill(16'h00BB), 1'b0, 1'b1, skew,  1'b0};
        tbl[6] = '{8'h00, '0,             1'b1, 1'b0, '0,    1'b0};
        tbl[7] = '{8'h00, '0,             1'b1, 1'b0, '0,    1'b1};
        // push + rd on empty lanes: push lands, pop refused, underflow stays
        tbl[8] = '{8'hFF, row_a,          1'b1, 1'b1, row_a, 1'b1};

        reset = 1'b0;
        idle();
        do_reset();
        chk("rst_valid",     W'(bus.o_valid),     W'(0));
        chk("rst_out",       bus.o_out,           '0);
        chk("rst_full",      W'(bus.o_full),      W'(0));
        chk("rst_ready",     W'(bus.o_ready),     W'(1));
        chk("rst_overflow",  W'(bus.o_overflow),  W'(0));
        chk("rst_underflow", W'(bus.o_underflow), W'(0));

        for (int k = 0; k < 9; k++) begin
            bus.wr = tbl[k].wr;
            bus.in = tbl[k].din;
            bus.rd = tbl[k].rd;
            tick();
            idle();
            chk($sformatf("vec%0d_valid", k), W'(bus.o_valid), W'(tbl[k].ev));
            chk($sformatf("vec%0d_out", k), bus.o_out, tbl[k].eout);
            chk($sformatf("vec%0d_unf", k), W'(bus.o_underflow), W'(tbl[k].eunf));
            chk($sformatf("vec%0d_ovf", k), W'(bus.o_overflow), W'(0));
            chk($sformatf("vec%0d_full", k), W'(bus.o_full), W'(0));
        end

        // Fill to depth, overflow on the 65th push, drain in order.
        do_reset();
        for (int v = 0; v < 63; v++) push_row(PBW'(v));
        chk("fill63_full", W'(bus.o_full), W'(0));
        push_row(PBW'(63));
        chk("fill64_full",  W'(bus.o_full),     W'(1));
        chk("fill64_ready", W'(bus.o_ready),    W'(0));
        chk("fill64_ovf",   W'(bus.o_overflow), W'(0));
        push_row(PBW'(99));
        chk("push65_ovf",  W'(bus.o_overflow), W'(1));
        chk("push65_full", W'(bus.o_full),     W'(1));
        for (int v = 0; v < 64; v++) begin
            chk($sformatf("drain%0d_valid", v), W'(bus.o_valid), W'(1));
            chk($sformatf("drain%0d_out", v), bus.o_out, fill(PBW'(v)));
            pop_row();
        end
        chk("drained_valid", W'(bus.o_valid), W'(0));
        chk("drained_out",   bus.o_out,       '0);
        chk("drained_full",  W'(bus.o_full),  W'(0));

        // Full with simultaneous push and pop.
        do_reset();
        for (int v = 0; v < 64; v++) push_row(PBW'(v));
        bus.wr = '1;
        bus.in = fill(16'd200);
        bus.rd = 1'b1;
        tick();
        idle();
        chk("fullrw_full", W'(bus.o_full),     W'(1));
        chk("fullrw_ovf",  W'(bus.o_overflow), W'(0));
        for (int v = 1; v < 65; v++) begin
            chk($sformatf("fullrw_pop%0d", v), bus.o_out,
                fill((v == 64) ? 16'd200 : PBW'(v)));
            pop_row();
        end
        chk("fullrw_empty", W'(bus.o_valid), W'(0));

        // Alternating push/pop across pointer wrap.
        do_reset();
        for (int n = 0; n < 100; n++) begin
            push_row(PBW'(16'h1000 + n));
            chk($sformatf("wrap%0d_out", n), bus.o_out, fill(PBW'(16'h1000 + n)));
            pop_row();
            chk($sformatf("wrap%0d_valid", n), W'(bus.o_valid), W'(0));
            chk($sformatf("wrap%0d_full", n), W'(bus.o_full), W'(0));
        end

        // Asynchronous reset between edges with 10 rows held.
        do_reset();
        pop_row();
        chk("arst_pre_unf", W'(bus.o_underflow), W'(1));
        for (int v = 0; v < 10; v++) push_row(PBW'(v + 50));
        chk("arst_pre_valid", W'(bus.o_valid), W'(1));
        #3;
        reset = 1'b1;
        #1;
        chk("arst_valid", W'(bus.o_valid),     W'(0));
        chk("arst_out",   bus.o_out,           '0);
        chk("arst_full",  W'(bus.o_full),      W'(0));
        chk("arst_unf",   W'(bus.o_underflow), W'(0));
        chk("arst_ovf",   W'(bus.o_overflow),  W'(0));
        #1;
        reset = 1'b0;
        push_row(16'h0777);
        chk("arst_push_valid", W'(bus.o_valid), W'(1));
        chk("arst_push_out",   bus.o_out,       fill(16'h0777));
        pop_row();
        chk("arst_pop_valid", W'(bus.o_valid), W'(0));
        chk("arst_pop_unf",   W'(bus.o_underflow), W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
